// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types and constants for the fetch-stage PC sequencer.
//   seq_state_t      sequencer states (BOOT, RUN, FREEZE, HALT)
//   redirect_kind_t  kind of a held redirect (NONE, BRANCH, TRAP)
//   redirect_t       kind + target address of a redirect
//   merge_redirect   folds newly arriving redirects into a held one
package pc_seq_pkg;

    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] DEFAULT_TRAP_VECTOR = 32'h0000_0080;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FREEZE,
        HALT
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE,
        BRANCH,
        TRAP
    } redirect_kind_t;

    typedef struct packed {
        redirect_kind_t    kind;
        logic [ADDR_W-1:0] addr;
    } redirect_t;

    // A trap always wins and replaces whatever is held. A branch replaces a
    // held branch (newest wins) but never displaces a held trap.
    function automatic redirect_t merge_redirect(
        input redirect_t         held,
        input logic              trap,
        input logic              branch,
        input logic [ADDR_W-1:0] branch_addr,
        input logic [ADDR_W-1:0] trap_addr
    );
        redirect_t r;
        r = held;
        if (trap) begin
            r.kind = TRAP;
            r.addr = trap_addr;
        end else if (branch && held.kind != TRAP) begin
            r.kind = BRANCH;
            r.addr = branch_addr;
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle between the hazard unit / branch resolution side
// and the PC sequencer, plus the sequencer's controls for the PC register.
//   inputs to sequencer : stall_req, imem_ready, branch_taken, branch_target,
//                         trap_req, halt_req, resume
//   outputs of sequencer: pc_reset, pc_pause, pc_override, pc_target,
//                         flush_if, halted
//   PC_SEQ_PERF_EN      : adds stall_cycles and redirect_count outputs
// Modports: master = environment side, slave = sequencer side.
interface pc_sequencer_if;
    import pc_seq_pkg::*;

    logic              stall_req;
    logic              imem_ready;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              trap_req;
    logic              halt_req;
    logic              resume;

    logic              pc_reset;
    logic              pc_pause;
    logic              pc_override;
    logic [ADDR_W-1:0] pc_target;
    logic              flush_if;
    logic              halted;
`ifdef PC_SEQ_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       redirect_count;
`endif

    modport master (
        output stall_req, imem_ready, branch_taken, branch_target,
               trap_req, halt_req, resume,
        input  pc_reset, pc_pause, pc_override, pc_target, flush_if, halted
`ifdef PC_SEQ_PERF_EN
        , input stall_cycles, redirect_count
`endif
    );

    modport slave (
        input  stall_req, imem_ready, branch_taken, branch_target,
               trap_req, halt_req, resume,
        output pc_reset, pc_pause, pc_override, pc_target, flush_if, halted
`ifdef PC_SEQ_PERF_EN
        , output stall_cycles, redirect_count
`endif
    );

endinterface

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: pending-redirect register. Captures branch/trap requests
// while capture_en is high, applying trap-over-branch priority, and clears on
// the edge the sequencer applies the redirect.
// Ports:
//   clock, reset (async, active-low)
//   capture_en                 high outside BOOT
//   trap_req, branch_taken     redirect pulses
//   branch_target              branch redirect address
//   apply                      redirect is being applied this cycle
//   pending_valid/addr/kind    currently held redirect
module pc_redirect_hold
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              capture_en,
    input  logic              trap_req,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              apply,
    output logic              pending_valid,
    output logic [ADDR_W-1:0] pending_addr,
    output redirect_kind_t    pending_kind
);

    redirect_t held;

    // Apply takes precedence: anything arriving in the applied cycle is
    // already folded into the applied target, so nothing is left to hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            held <= '{kind: NONE, addr: '0};
        end else if (apply) begin
            held.kind <= NONE;
        end else if (capture_en) begin
            held <= merge_redirect(held, trap_req, branch_taken,
                                   branch_target, TRAP_VECTOR);
        end
    end

    assign pending_valid = (held.kind != NONE);
    assign pending_addr  = held.addr;
    assign pending_kind  = held.kind;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives the fetch-stage PC register's reset, pause and
// override controls. Handles boot, stalls, imem wait states, branch/trap
// redirects (held while frozen or halted), halt/resume and IF/ID flush.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    pc_sequencer_if.slave (requests in, PC register controls out)
// Parameters: BOOT_CYCLES (1..255), FLUSH_DEPTH (1..7), TRAP_VECTOR.
// Optional: PC_SEQ_PERF_EN adds stall_cycles and redirect_count counters.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       BOOT_CYCLES = 4,
    parameter int unsigned       FLUSH_DEPTH = 2,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    localparam logic [7:0] BOOT_LAST  = 8'(BOOT_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    seq_state_t        state, state_next;
    logic [7:0]        boot_cnt;
    logic [2:0]        flush_cnt;
    logic [ADDR_W-1:0] last_target;

    logic              freeze;
    logic              capture_en;
    logic              apply;
    logic              redirect_valid;
    logic              seq_reset;
    logic              seq_pause;
    logic              seq_halted;

    logic              pending_valid;
    logic [ADDR_W-1:0] pending_addr;
    redirect_kind_t    pending_kind;
    redirect_t         selected;

    assign freeze     = bus.stall_req | ~bus.imem_ready;
    assign capture_en = (state != BOOT);

    pc_redirect_hold #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_hold (
        .clock         (clock),
        .reset         (reset),
        .capture_en    (capture_en),
        .trap_req      (bus.trap_req),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .apply         (apply),
        .pending_valid (pending_valid),
        .pending_addr  (pending_addr),
        .pending_kind  (pending_kind)
    );

    // A redirect arriving this cycle is merged with the held one so it can
    // be applied with zero latency when fetch is not frozen.
    assign selected = merge_redirect('{kind: pending_kind, addr: pending_addr},
                                     bus.trap_req & capture_en,
                                     bus.branch_taken & capture_en,
                                     bus.branch_target, TRAP_VECTOR);
    assign redirect_valid = pending_valid |
                            (capture_en & (bus.trap_req | bus.branch_taken));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    // FREEZE differs from RUN only in name: its first unfrozen cycle behaves
    // exactly like RUN, including halt entry and redirect application.
    always_comb begin
        state_next = state;
        seq_reset  = 1'b0;
        seq_pause  = 1'b0;
        seq_halted = 1'b0;
        apply      = 1'b0;
        case (state)
            BOOT: begin
                seq_reset = 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state_next = RUN;
                end
            end
            RUN, FREEZE: begin
                if (freeze) begin
                    seq_pause  = 1'b1;
                    state_next = FREEZE;
                end else begin
                    apply      = redirect_valid;
                    state_next = bus.halt_req ? HALT : RUN;
                end
            end
            HALT: begin
                seq_pause  = 1'b1;
                seq_halted = 1'b1;
                if (bus.resume) begin
                    state_next = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // Boot counter, flush counter and the last applied target.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            boot_cnt    <= '0;
            flush_cnt   <= '0;
            last_target <= '0;
        end else begin
            if (state == BOOT && boot_cnt != BOOT_LAST) begin
                boot_cnt <= boot_cnt + 8'd1;
            end
            if (apply) begin
                flush_cnt   <= FLUSH_LOAD;
                last_target <= selected.addr;
            end else if (flush_cnt != 3'd0) begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

    assign bus.pc_reset    = seq_reset;
    assign bus.pc_pause    = seq_pause;
    assign bus.pc_override = apply;
    assign bus.pc_target   = apply ? selected.addr : last_target;
    assign bus.flush_if    = apply | (flush_cnt != 3'd0);
    assign bus.halted      = seq_halted;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (seq_pause && (state == FREEZE || state == HALT)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (apply) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end

    assign bus.stall_cycles   = stall_cycles;
    assign bus.redirect_count = redirect_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer. A downstream PC
// register is modelled from the DUT outputs; expected outputs come from a
// cycle-level behavioural model kept in this file.
module tb_pc_sequencer;

    localparam int          BOOT_CYCLES = 4;
    localparam int          FLUSH_DEPTH = 2;
    localparam logic [31:0] TRAP_VEC    = 32'h0000_0080;
    localparam logic [36:0] RESET_VEC   = {5'b10000, 32'h0};

    logic        clock;
    logic        reset;
    logic [31:0] dut_pc;
    int          errors;
    int          checks;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .TRAP_VECTOR (TRAP_VEC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream PC register driven by the DUT's controls.
    always @(posedge clock) begin
        if (bus.pc_reset)         dut_pc <= 32'hFFFF_FFFC;
        else if (!bus.pc_pause)   dut_pc <= bus.pc_override ? bus.pc_target : dut_pc + 32'd4;
    end

    // Behavioural model state: countdowns and flags, not the DUT's FSM.
    int          m_boot_left;
    bit          m_halted;
    bit          m_pend;
    bit          m_pend_trap;
    logic [31:0] m_pend_addr;
    int          m_flush_left;
    logic [31:0] m_last_tgt;
    logic [31:0] m_pc;
    bit          m_freeze;
    bit          t_pend;
    bit          t_trap;
    logic [31:0] t_addr;
    bit          e_reset, e_pause, e_override, e_flush, e_halted;
    logic [31:0] e_target;

    function automatic void model_outputs();
        bit booting;
        booting  = (m_boot_left > 0);
        m_freeze = bus.stall_req || !bus.imem_ready;
        t_pend   = m_pend;
        t_trap   = m_pend_trap;
        t_addr   = m_pend_addr;
        if (!booting) begin
            if (bus.trap_req) begin
                t_pend = 1; t_trap = 1; t_addr = TRAP_VEC;
            end else if (bus.branch_taken && !(t_pend && t_trap)) begin
                t_pend = 1; t_trap = 0; t_addr = bus.branch_target;
            end
        end
        e_reset    = booting;
        e_halted   = !booting && m_halted;
        e_pause    = !booting && (m_halted || m_freeze);
        e_override = !booting && !m_halted && !m_freeze && t_pend;
        e_target   = e_override ? t_addr : m_last_tgt;
        e_flush    = e_override || (m_flush_left > 0);
    endfunction

    function automatic void model_reset();
        m_boot_left  = BOOT_CYCLES;
        m_halted     = 0;
        m_pend       = 0;
        m_pend_trap  = 0;
        m_pend_addr  = '0;
        m_flush_left = 0;
        m_last_tgt   = '0;
        m_pc         = 32'hFFFF_FFFC;
        model_outputs();
    endfunction

    function automatic void model_advance();
        model_outputs();
        if (e_reset)          m_pc = 32'hFFFF_FFFC;
        else if (!e_pause)    m_pc = e_override ? e_target : m_pc + 32'd4;
        if (m_boot_left > 0) begin
            m_boot_left--;
        end else begin
            if (e_override) m_pend = 0;
            else begin
                m_pend = t_pend; m_pend_trap = t_trap; m_pend_addr = t_addr;
            end
            if (m_halted) begin
                if (bus.resume) m_halted = 0;
            end else if (!m_freeze && bus.halt_req) begin
                m_halted = 1;
            end
            if (e_override) begin
                m_flush_left = FLUSH_DEPTH - 1;
                m_last_tgt   = e_target;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end
        end
    endfunction

    function automatic logic [36:0] dut_vec();
        return {bus.pc_reset, bus.pc_pause, bus.pc_override, bus.flush_if,
                bus.halted, bus.pc_target};
    endfunction

    function automatic logic [36:0] exp_vec();
        return {e_reset, e_pause, e_override, e_flush, e_halted, e_target};
    endfunction

    // One clock: model follows the edge, new inputs go on at the falling
    // edge, expectations are evaluated just after.
    task automatic apply_stimulus(input logic stall, input logic ready,
                                  input logic br, input logic [31:0] tgt,
                                  input logic trap, input logic halt,
                                  input logic res);
        @(posedge clock);
        if (reset) model_advance();
        @(negedge clock);
        bus.stall_req     = stall;
        bus.imem_ready    = ready;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.trap_req      = trap;
        bus.halt_req      = halt;
        bus.resume        = res;
        #1;
        model_outputs();
    endtask

    task automatic idle();
        apply_stimulus(0, 1, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (dut_vec() !== RESET_VEC) begin
                errors++;
                $display("[TB] FAIL reset_hold c%0d got=%h want=%h", i, dut_vec(), RESET_VEC);
            end
        end
    endtask

    task automatic test_boot();
        int hi;
        @(negedge clock);
        reset = 1'b1;
        #1;
        hi = int'(bus.pc_reset);
        for (int i = 1; i <= 7; i++) begin
            idle();
            hi += int'(bus.pc_reset);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL boot_c%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
            if (i >= 5) begin
                checks++;
                if (dut_pc !== 32'((i - 5) * 4)) begin
                    errors++;
                    $display("[TB] FAIL boot_pc_c%0d got=%h want=%h", i, dut_pc, 32'((i - 5) * 4));
                end
            end
        end
        checks++;
        if (hi != BOOT_CYCLES) begin
            errors++;
            $display("[TB] FAIL boot_len got=%0d want=%0d", hi, BOOT_CYCLES);
        end
    endtask

    task automatic test_branch();
        apply_stimulus(0, 1, 1, 32'h200, 0, 0, 0);
        checks++;
        if ({bus.pc_override, bus.flush_if, bus.pc_target} !== {2'b11, 32'h200}) begin
            errors++;
            $display("[TB] FAIL branch_apply got=%b%b/%h want=11/00000200", bus.pc_override, bus.flush_if, bus.pc_target);
        end
        idle();
        checks++;
        if ({bus.flush_if, bus.pc_override, dut_pc} !== {2'b10, 32'h200}) begin
            errors++;
            $display("[TB] FAIL branch_next got=%b%b/%h want=10/00000200", bus.flush_if, bus.pc_override, dut_pc);
        end
        idle();
        checks++;
        if ({bus.flush_if, dut_pc} !== {1'b0, 32'h204}) begin
            errors++;
            $display("[TB] FAIL branch_after got=%b/%h want=0/00000204", bus.flush_if, dut_pc);
        end
    endtask

    task automatic test_stall_branch();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1, 1, (i == 1), 32'h300, 0, 0, 0);
            checks++;
            if ({bus.pc_pause, bus.pc_override} !== 2'b10 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL stall_c%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        idle();
        checks++;
        if ({bus.pc_pause, bus.pc_override, bus.pc_target} !== {2'b01, 32'h300}) begin
            errors++;
            $display("[TB] FAIL stall_release got=%b%b/%h want=01/00000300", bus.pc_pause, bus.pc_override, bus.pc_target);
        end
        idle();
        checks++;
        if (dut_pc !== 32'h300) begin
            errors++;
            $display("[TB] FAIL stall_pc got=%h want=00000300", dut_pc);
        end
    endtask

    task automatic test_trap_branch();
        apply_stimulus(0, 0, 1, 32'h400, 1, 0, 0);
        checks++;
        if ({bus.pc_pause, bus.pc_override} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL trap_frozen got=%b%b want=10", bus.pc_pause, bus.pc_override);
        end
        idle();
        checks++;
        if ({bus.pc_override, bus.pc_target} !== {1'b1, TRAP_VEC}) begin
            errors++;
            $display("[TB] FAIL trap_apply got=%b/%h want=1/%h", bus.pc_override, bus.pc_target, TRAP_VEC);
        end
        for (int i = 0; i < 2; i++) begin
            idle();
            checks++;
            if ({bus.pc_override, dut_pc} !== {1'b0, TRAP_VEC + 32'(4 * i)}) begin
                errors++;
                $display("[TB] FAIL trap_after_c%0d got=%b/%h want=0/%h", i, bus.pc_override, dut_pc, TRAP_VEC + 32'(4 * i));
            end
        end
    endtask

    task automatic test_halt();
        // Stimulus rows: {halt, resume, branch}, expected halted, expected override.
        logic [2:0] stim [11] = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000,
                                  3'b100, 3'b100, 3'b110, 3'b100, 3'b010};
        logic       want_h [11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 1};
        logic       want_o [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(0, 1, stim[i][0], 32'h500, 0, stim[i][2], stim[i][1]);
            checks++;
            if ({bus.halted, bus.pc_override} !== {want_h[i], want_o[i]} ||
                (want_h[i] && bus.pc_pause !== 1'b1) ||
                (want_o[i] && bus.pc_target !== 32'h500) ||
                dut_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL halt_c%0d got=%h want=%h halted/ovr want=%b%b", i, dut_vec(), exp_vec(), want_h[i], want_o[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_freeze();
        int hi;
        apply_stimulus(1, 1, 0, 32'h0, 0, 0, 0);
        apply_stimulus(1, 1, 1, 32'h600, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++;
            $display("[TB] FAIL reset_async got=%h want=%h", dut_vec(), RESET_VEC);
        end
        model_reset();
        @(negedge clock);
        bus.stall_req    = 0;
        bus.branch_taken = 0;
        reset = 1'b1;
        #1;
        model_outputs();
        hi = int'(bus.pc_reset);
        for (int i = 1; i <= 7; i++) begin
            idle();
            hi += int'(bus.pc_reset);
            checks++;
            if (dut_vec() !== exp_vec() || (i >= 4 && bus.pc_override !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL reboot_c%0d got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (hi != BOOT_CYCLES) begin
            errors++;
            $display("[TB] FAIL reboot_len got=%0d want=%0d", hi, BOOT_CYCLES);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            apply_stimulus(($urandom_range(99) < 20), ($urandom_range(99) < 80),
                           ($urandom_range(99) < 12), $urandom() & 32'hFFFF_FFFC,
                           ($urandom_range(99) < 4), ($urandom_range(99) < 5),
                           ($urandom_range(99) < 20));
            checks++;
            if (dut_vec() !== exp_vec() || dut_pc !== m_pc) begin
                errors++;
                $display("[TB] FAIL random_c%0d got=%h pc=%h want=%h pc=%h", i, dut_vec(), dut_pc, exp_vec(), m_pc);
            end
        end
    endtask

    initial begin
        errors            = 0;
        checks            = 0;
        reset             = 1'b0;
        bus.stall_req     = 1'b0;
        bus.imem_ready    = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.trap_req      = 1'b0;
        bus.halt_req      = 1'b0;
        bus.resume        = 1'b0;
        model_reset();

        test_reset();
        test_boot();
        test_branch();
        test_stall_branch();
        test_trap_branch();
        test_halt();
        test_reset_mid_freeze();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
